riscv_dmem_arbiter: RTL and testbench

//  Shares the single-port data BRAM between the CPU load/store port and the UART

---
 rtl/riscv_dmem_arbiter_pkg.sv | 25 ++
 rtl/riscv_wr_fifo.sv | 45 ++++
 rtl/riscv_dmem_arbiter.sv | 114 +++++++++++
 tb/tb_riscv_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, grant owners and
// the grant-selection rule.
package riscv_dmem_arbiter_pkg;

    typedef enum logic {
        ARB_ST_IDLE = 1'b0,
        ARB_ST_RD   = 1'b1
    } arb_state_t;

    typedef enum logic {
        ARB_GNT_CPU = 1'b0,
        ARB_GNT_UPG = 1'b1
    } arb_gnt_t;

    localparam logic [3:0] MEM_WE_WORD = 4'hF;
    localparam logic [3:0] MEM_WE_NONE = 4'h0;

    // Round-robin tie break: the side that did not win last time goes first.
    function automatic logic pick_upg(input logic cpu_cand, input logic upg_cand,
                                      input arb_gnt_t last_grant);
        if (cpu_cand && upg_cand) return last_grant == ARB_GNT_CPU;
        return upg_cand;
    endfunction

endpackage

// File: rtl/riscv_wr_fifo.sv
// Small synchronous FIFO for programmer word writes. A pop frees the head slot
// in the same cycle, so push+pop is accepted even when full.
module riscv_wr_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Shares the single-port data BRAM between CPU loads/stores and the UART
// programmer write stream, sequencing the one-cycle BRAM read latency.
module riscv_dmem_arbiter
    import riscv_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              upg_wen,
    input  logic [ADDR_W-1:0] upg_adr,
    input  logic [DATA_W-1:0] upg_dat,
    input  logic              upg_done,
    output logic              prog_mode,
    output logic              upg_ovf,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int ENT_W = ADDR_W + DATA_W;

    arb_state_t        state;
    arb_gnt_t          last_grant;
    logic              seen_upg;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  fifo_head;
    logic              cpu_cand;
    logic              upg_cand;
    logic              gnt_upg;
    logic              gnt_cpu;
    logic              cpu_load;
    logic [ADDR_W-1:0] cpu_word;
    logic              unused_addr_bits;

    // The BRAM wraps: byte-address bits above the word index are don't-care.
    assign cpu_word         = cpu_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};
    assign cpu_load         = cpu_we == MEM_WE_NONE;

    assign cpu_cand = cpu_req && !prog_mode && !rst && state == ARB_ST_IDLE;
    assign upg_cand = !fifo_empty && !rst && state == ARB_ST_IDLE;
    assign gnt_upg  = pick_upg(cpu_cand, upg_cand, last_grant);
    assign gnt_cpu  = cpu_cand && !gnt_upg;

    riscv_wr_fifo #(
        .WIDTH(ENT_W),
        .DEPTH(FIFO_DEPTH)
    ) u_wr_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (upg_wen),
        .pop  (gnt_upg),
        .din  ({upg_adr, upg_dat}),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (fifo_head)
    );

    always_comb begin
        mem_en    = gnt_upg || gnt_cpu;
        mem_we    = MEM_WE_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_upg) begin
            mem_we    = MEM_WE_WORD;
            mem_addr  = fifo_head[ENT_W-1 -: ADDR_W];
            mem_wdata = fifo_head[DATA_W-1:0];
        end else if (gnt_cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_word;
            mem_wdata = cpu_wdata;
        end
    end

    // Handshake: cpu_req is a level held while cpu_stall=1; a store completes
    // in its grant cycle, a load completes in the following cycle with cpu_rvalid=1.
    assign cpu_rvalid = state == ARB_ST_RD;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign cpu_stall  = cpu_req && !rst && !(gnt_cpu && !cpu_load) && !cpu_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_ST_IDLE;
            last_grant <= ARB_GNT_CPU;
            seen_upg   <= 1'b0;
            prog_mode  <= 1'b0;
            upg_ovf    <= 1'b0;
        end else begin
            state <= (gnt_cpu && cpu_load) ? ARB_ST_RD : ARB_ST_IDLE;
            if (gnt_upg)      last_grant <= ARB_GNT_UPG;
            else if (gnt_cpu) last_grant <= ARB_GNT_CPU;
            if (upg_wen) seen_upg <= 1'b1;
            // Only the first programmer write after reset enters programming mode.
            if (!prog_mode && upg_wen && !seen_upg)
                prog_mode <= 1'b1;
            else if (prog_mode && upg_done && fifo_empty && !gnt_upg)
                prog_mode <= 1'b0;
            if (upg_wen && fifo_full && !gnt_upg) upg_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: directed vector table, hand sequences for FIFO
// overflow and reset-in-RD, then random traffic against a queue-based model.
module tb_riscv_dmem_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int WORDS  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_stall, cpu_rvalid;
    logic [3:0]  cpu_we, mem_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        upg_wen, upg_done, prog_mode, upg_ovf, mem_en;
    logic [13:0] upg_adr, mem_addr;
    logic [31:0] upg_dat, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    riscv_dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .upg_wen(upg_wen), .upg_adr(upg_adr), .upg_dat(upg_dat), .upg_done(upg_done),
        .prog_mode(prog_mode), .upg_ovf(upg_ovf),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'h10000000 | 32'(i));
    endfunction

    // BRAM with one-cycle read latency
    logic        init_mem;
    logic [31:0] bram [WORDS];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < WORDS; i++) bram[i] <= init_val(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= bram[mem_addr];
        end
    end

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: memory image, pending-write queue, a few flags
    typedef struct packed {
        logic [13:0] adr;
        logic [31:0] dat;
    } ent_t;

    ent_t        ref_q[$];
    logic [31:0] ref_mem [WORDS];
    logic [31:0] m_load;
    bit          m_rd, m_last_cpu, m_prog, m_seen, m_ovf, m_live, m_stall;
    logic [13:0] exp_q[$];

    task automatic model_step();
        bit          fifo_c, cpu_c, g_fifo, g_cpu;
        logic [13:0] w;
        int          pre;
        ent_t        e;
        w      = cpu_addr[15:2];
        fifo_c = !rst && !m_rd && ref_q.size() > 0;
        cpu_c  = !rst && !m_rd && cpu_req && !m_prog;
        g_fifo = fifo_c && (!cpu_c || m_last_cpu);
        g_cpu  = cpu_c && !g_fifo;
        m_stall = !rst && cpu_req && !m_rd && !(g_cpu && cpu_we != 4'h0);
        if (!rst && m_live) begin
            chk("stall", cpu_stall, m_stall);
            chk("rvalid", cpu_rvalid, m_rd);
            chk("rdata", cpu_rdata, m_rd ? m_load : 32'd0);
            chk("prog_mode", prog_mode, m_prog);
            chk("upg_ovf", upg_ovf, m_ovf);
            chk("mem_en", mem_en, g_fifo || g_cpu);
            chk("mem_we", mem_we, g_fifo ? 32'hF : (g_cpu ? {28'd0, cpu_we} : 32'd0));
            if (g_fifo) begin
                chk("mem_addr_upg", mem_addr, ref_q[0].adr);
                chk("mem_wdata_upg", mem_wdata, ref_q[0].dat);
            end else if (g_cpu) begin
                chk("mem_addr_cpu", mem_addr, w);
                if (cpu_we != 4'h0) chk("mem_wdata_cpu", mem_wdata, cpu_wdata);
            end
        end
        if (rst) begin
            ref_q.delete();
            m_rd = 0; m_last_cpu = 1; m_prog = 0; m_seen = 0; m_ovf = 0; m_live = 1;
        end else begin
            pre = ref_q.size();
            if (g_fifo) begin
                ref_mem[ref_q[0].adr] = ref_q[0].dat;
                ref_q.delete(0);
                m_last_cpu = 0;
            end
            if (g_cpu) begin
                m_last_cpu = 1;
                if (cpu_we == 4'h0) m_load = ref_mem[w];
                else for (int b = 0; b < 4; b++)
                    if (cpu_we[b]) ref_mem[w][8*b +: 8] = cpu_wdata[8*b +: 8];
            end
            m_rd = g_cpu && cpu_we == 4'h0;
            if (m_prog && upg_done && pre == 0) m_prog = 0;
            else if (!m_prog && upg_wen && !m_seen) m_prog = 1;
            if (upg_wen) begin
                if (ref_q.size() < DEPTH) begin
                    e.adr = upg_adr;
                    e.dat = upg_dat;
                    ref_q.push_back(e);
                end else m_ovf = 1;
                m_seen = 1;
            end
        end
    endtask

    task automatic drive(input logic req, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic wen, input logic [13:0] adr,
                         input logic [31:0] dat, input logic done);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        upg_wen = wen; upg_adr = adr; upg_dat = dat; upg_done = done;
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        finish_cycle();
    endtask

    typedef struct {
        logic req; logic [3:0] we; logic [31:0] addr; logic [31:0] wdata;
        logic wen; logic [13:0] adr; logic [31:0] dat; logic done;
        logic x_stall; logic x_rvalid; logic [31:0] x_rdata;
        logic x_en; logic [3:0] x_we; logic [13:0] x_addr; logic x_prog;
    } vec_t;

    function automatic vec_t v(input logic req, input logic [3:0] we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic wen, input logic [13:0] adr,
                               input logic [31:0] dat, input logic done, input logic x_stall,
                               input logic x_rvalid, input logic [31:0] x_rdata, input logic x_en,
                               input logic [3:0] x_we, input logic [13:0] x_addr, input logic x_prog);
        vec_t t;
        t.req = req; t.we = we; t.addr = addr; t.wdata = wdata;
        t.wen = wen; t.adr = adr; t.dat = dat; t.done = done;
        t.x_stall = x_stall; t.x_rvalid = x_rvalid; t.x_rdata = x_rdata;
        t.x_en = x_en; t.x_we = x_we; t.x_addr = x_addr; t.x_prog = x_prog;
        return t;
    endfunction

    task automatic apply_vec(input vec_t t, input int idx);
        drive(t.req, t.we, t.addr, t.wdata, t.wen, t.adr, t.dat, t.done);
        @(negedge clk);
        chk($sformatf("vec%0d_stall", idx), cpu_stall, t.x_stall);
        chk($sformatf("vec%0d_rvalid", idx), cpu_rvalid, t.x_rvalid);
        chk($sformatf("vec%0d_rdata", idx), cpu_rdata, t.x_rdata);
        chk($sformatf("vec%0d_en", idx), mem_en, t.x_en);
        chk($sformatf("vec%0d_we", idx), mem_we, t.x_we);
        if (t.x_en) chk($sformatf("vec%0d_addr", idx), mem_addr, t.x_addr);
        chk($sformatf("vec%0d_prog", idx), prog_mode, t.x_prog);
        chk($sformatf("vec%0d_ovf", idx), upg_ovf, 1'b0);
        finish_cycle();
    endtask

    vec_t tbl [20];

    initial begin
        logic        r_req;
        logic [3:0]  r_we;
        logic [31:0] r_addr, r_wdata;
        bit          hold;
        int          n, pct;

        checks = 0; errors = 0; m_live = 0; m_stall = 0; init_mem = 1'b1;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);

        // req we addr wdata | wen adr dat done | stall rvalid rdata | en we addr | prog
        tbl[0]  = v(0, 4'h0, 32'h0,  32'h0,        0, 14'd0, 32'h0,        0, 0, 0, 32'h0,        0, 4'h0, 14'd0,  0);
        tbl[1]  = v(1, 4'h0, 32'h10, 32'h0,        0, 14'd0, 32'h0,        0, 1, 0, 32'h0,        1, 4'h0, 14'd4,  0);
        tbl[2]  = v(1, 4'h0, 32'h10, 32'h0,        0, 14'd0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 0, 4'h0, 14'd0,  0);
        tbl[3]  = v(1, 4'h3, 32'h20, 32'h12345678, 0, 14'd0, 32'h0,        0, 0, 0, 32'h0,        1, 4'h3, 14'd8,  0);
        tbl[4]  = v(0, 4'h0, 32'h0,  32'h0,        0, 14'd0, 32'h0,        0, 0, 0, 32'h0,        0, 4'h0, 14'd0,  0);
        tbl[5]  = v(0, 4'h0, 32'h0,  32'h0,        1, 14'd0, 32'hA0000000, 0, 0, 0, 32'h0,        0, 4'h0, 14'd0,  0);
        tbl[6]  = v(1, 4'hF, 32'h40, 32'hCAFEF00D, 1, 14'd1, 32'hA1111111, 0, 1, 0, 32'h0,        1, 4'hF, 14'd0,  1);
        tbl[7]  = v(1, 4'hF, 32'h40, 32'hCAFEF00D, 1, 14'd2, 32'hA2222222, 0, 1, 0, 32'h0,        1, 4'hF, 14'd1,  1);
        tbl[8]  = v(1, 4'hF, 32'h40, 32'hCAFEF00D, 0, 14'd0, 32'h0,        0, 1, 0, 32'h0,        1, 4'hF, 14'd2,  1);
        tbl[9]  = v(1, 4'hF, 32'h40, 32'hCAFEF00D, 0, 14'd0, 32'h0,        1, 1, 0, 32'h0,        0, 4'h0, 14'd0,  1);
        tbl[10] = v(1, 4'hF, 32'h40, 32'hCAFEF00D, 0, 14'd0, 32'h0,        1, 0, 0, 32'h0,        1, 4'hF, 14'h10, 0);
        tbl[11] = v(0, 4'h0, 32'h0,  32'h0,        1, 14'd5, 32'h55555555, 1, 0, 0, 32'h0,        0, 4'h0, 14'd0,  0);
        tbl[12] = v(1, 4'h0, 32'h14, 32'h0,        0, 14'd0, 32'h0,        1, 1, 0, 32'h0,        1, 4'hF, 14'd5,  0);
        tbl[13] = v(1, 4'h0, 32'h14, 32'h0,        0, 14'd0, 32'h0,        1, 1, 0, 32'h0,        1, 4'h0, 14'd5,  0);
        tbl[14] = v(1, 4'h0, 32'h14, 32'h0,        0, 14'd0, 32'h0,        1, 0, 1, 32'h55555555, 0, 4'h0, 14'd0,  0);
        tbl[15] = v(1, 4'h0, 32'h40, 32'h0,        0, 14'd0, 32'h0,        0, 1, 0, 32'h0,        1, 4'h0, 14'h10, 0);
        tbl[16] = v(1, 4'h0, 32'h40, 32'h0,        0, 14'd0, 32'h0,        0, 0, 1, 32'hCAFEF00D, 0, 4'h0, 14'd0,  0);
        tbl[17] = v(1, 4'h0, 32'h20, 32'h0,        0, 14'd0, 32'h0,        0, 1, 0, 32'h0,        1, 4'h0, 14'd8,  0);
        tbl[18] = v(1, 4'h0, 32'h20, 32'h0,        0, 14'd0, 32'h0,        0, 0, 1, 32'h10005678, 0, 4'h0, 14'd0,  0);
        tbl[19] = v(0, 4'h0, 32'h0,  32'h0,        0, 14'd0, 32'h0,        0, 0, 0, 32'h0,        0, 4'h0, 14'd0,  0);

        // clock/reset
        rst = 1'b1;
        drive(0, 4'h0, 32'h0, 32'h0, 0, 14'd0, 32'h0, 0);
        cycle();
        init_mem = 1'b0;
        cycle();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) apply_vec(tbl[i], i);

        // FIFO fills behind alternating CPU loads; the 7th push finds it full
        for (int i = 0; i < 7; i++) begin
            drive(1, 4'h0, 32'h100, 32'h0, 1, 14'(32'h20 + i), 32'hB0000000 + 32'(i), 0);
            cycle();
        end
        for (int i = 2; i < 6; i++) exp_q.push_back(14'(32'h20 + i));
        drive(0, 4'h0, 32'h0, 32'h0, 0, 14'd0, 32'h0, 0);
        @(negedge clk);
        chk("ovf_set", upg_ovf, 1'b1);
        chk("ovf_rd_rvalid", cpu_rvalid, 1'b1);
        finish_cycle();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_en && mem_we == 4'hF) begin
                n++;
                if (exp_q.size() > 0) chk("drain_addr", mem_addr, exp_q.pop_front());
            end
            finish_cycle();
        end
        chk("drain_count", n, 4);
        chk("ovf_sticky", upg_ovf, 1'b1);

        // Refill, then reset while a load is in its RD cycle
        for (int i = 0; i < 7; i++) begin
            drive(1, 4'h0, 32'h100, 32'h0, 1, 14'(32'h30 + i), 32'hC0000000 + 32'(i), 0);
            cycle();
        end
        drive(0, 4'h0, 32'h0, 32'h0, 0, 14'd0, 32'h0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_rvalid", cpu_rvalid, 1'b0);
            chk("rst_flush_en", mem_en, 1'b0);
            chk("rst_ovf", upg_ovf, 1'b0);
            chk("rst_prog", prog_mode, 1'b0);
            finish_cycle();
        end

        // Random traffic; CPU holds its request while stalled
        hold = 0; r_req = 0; r_we = 4'h0; r_addr = 32'h0; r_wdata = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                r_req   = $urandom_range(0, 99) < 60;
                r_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                r_addr  = {16'($urandom), 9'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
                r_wdata = $urandom;
            end
            pct = ((i / 500) % 2 == 1) ? 70 : 15;
            drive(r_req, r_we, r_addr, r_wdata, $urandom_range(0, 99) < pct,
                  14'($urandom_range(0, 31)), $urandom, ((i / 250) % 2) == 1);
            rst = $urandom_range(0, 199) == 0;
            cycle();
            hold = m_stall;
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
